// File: rtl/counter_modulo_updown_async_resetb_pkg.sv
// Shared constants for the counter benchmark family.
package counters_pkg;

  localparam int unsigned DEFAULT_WIDTH = 128;

  // Direction select (up_down input)
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Bound behaviour select (saturate input)
  localparam logic MODE_WRAP     = 1'b0;
  localparam logic MODE_SATURATE = 1'b1;

endpackage : counters_pkg

// File: rtl/counter_modulo_updown_async_resetb_if.sv
// Control and status bundle of the modulo up/down counter.
interface counter_modulo_updown_async_resetb_if
  import counters_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             up_down;
  logic             saturate;
  logic [WIDTH-1:0] limit;
  logic             clear_overflow;
  logic [WIDTH-1:0] result;
  logic             terminal_count;
  logic             overflow_sticky;

  // Controller side: drives commands, observes the count.
  modport master (
    output clear, load, load_value, enable, up_down, saturate, limit, clear_overflow,
    input  result, terminal_count, overflow_sticky
  );

  // Counter side.
  modport slave (
    input  clear, load, load_value, enable, up_down, saturate, limit, clear_overflow,
    output result, terminal_count, overflow_sticky
  );

endinterface : counter_modulo_updown_async_resetb_if

// File: rtl/counter_modulo_updown_async_resetb_next_value.sv
// Combinational step of the counter: next count and bound-event detect.
module counter_next_value
  import counters_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  input  logic             saturate,
  output logic [WIDTH-1:0] next_value_c,
  output logic             bound_event_c
);

  // Up: anything at or above limit is a bound (covers loads above limit).
  // Down: only zero is a bound; values above limit decrement normally.
  always_comb begin
    next_value_c  = result;
    bound_event_c = 1'b0;
    case (up_down)
      DIR_UP: begin
        if (result >= limit) begin
          bound_event_c = 1'b1;
          next_value_c  = (saturate == MODE_SATURATE) ? limit : '0;
        end else begin
          next_value_c  = result + WIDTH'(1);
        end
      end
      DIR_DOWN: begin
        if (result == '0) begin
          bound_event_c = 1'b1;
          next_value_c  = (saturate == MODE_WRAP) ? limit : '0;
        end else begin
          next_value_c  = result - WIDTH'(1);
        end
      end
      default: begin
        next_value_c  = result;
        bound_event_c = 1'b0;
      end
    endcase
  end

endmodule : counter_next_value

// File: rtl/counter_modulo_updown_async_resetb.sv
// Parametrised modulo up/down counter with wrap/saturate, load/clear,
// terminal-count pulse and sticky overflow flag.
module counter_modulo_updown_async_resetb
  import counters_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic clk,
  input  logic resetb,
  counter_modulo_updown_async_resetb_if.slave bus
);

  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH-1:0] next_value_c;
  logic             bound_event_c;

  counter_next_value #(
    .WIDTH (WIDTH)
  ) u_next_value (
    .result        (result_q),
    .limit         (bus.limit),
    .up_down       (bus.up_down),
    .saturate      (bus.saturate),
    .next_value_c  (next_value_c),
    .bound_event_c (bound_event_c)
  );

  // Priority mux: clear > load > enable > hold; a bound event beats clear_overflow.
  always_comb begin
    result_d = result_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q & ~bus.clear_overflow;
    if (bus.clear) begin
      result_d = RESET_VALUE;
      ovf_d    = 1'b0;
    end else if (bus.load) begin
      result_d = bus.load_value;
    end else if (bus.enable) begin
      result_d = next_value_c;
      tc_d     = bound_event_c;
      ovf_d    = ovf_d | bound_event_c;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      result_q <= RESET_VALUE;
      tc_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      tc_q     <= tc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.result          = result_q;
  assign bus.terminal_count  = tc_q;
  assign bus.overflow_sticky = ovf_q;

endmodule : counter_modulo_updown_async_resetb

// File: tb/tb_counter_modulo_updown_async_resetb.sv
// Bench for the modulo up/down counter: directed table, corner sequences,
// random traffic against an arithmetic reference model, and a 128-bit instance.
module tb_counter_modulo_updown_async_resetb;

  logic clk;
  logic resetb;

  counter_modulo_updown_async_resetb_if #(.WIDTH(8))   bus8 ();
  counter_modulo_updown_async_resetb_if #(.WIDTH(128)) bus128 ();

  counter_modulo_updown_async_resetb #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus8)
  );

  counter_modulo_updown_async_resetb #(.WIDTH(128), .RESET_VALUE(128'h0)) dut128 (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus128)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       c;
    logic       l;
    logic [7:0] lv;
    logic       e;
    logic       ud;
    logic       s;
    logic [7:0] lim;
    logic       co;
    logic [7:0] r;
    logic       tc;
    logic       ov;
  } vec_t;

  int n_vec;
  int n_bad;

  // Reference model state for the 8-bit instance
  int m_res;
  bit m_tc;
  bit m_ov;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Counter rules in plain integer arithmetic: modulo (limit+1) in range,
  // explicit handling of values loaded above limit.
  task automatic model_edge(input logic c, input logic l, input logic [7:0] lv,
                            input logic e, input logic ud, input logic s,
                            input logic [7:0] lim, input logic co);
    int li;
    bit bnd;
    li  = int'(lim);
    bnd = 1'b0;
    if (c) begin
      m_res = 0; m_tc = 1'b0; m_ov = 1'b0;
    end else if (l) begin
      m_res = int'(lv); m_tc = 1'b0;
      if (co) m_ov = 1'b0;
    end else if (e) begin
      if (ud) begin
        if (m_res > li) begin
          bnd = 1'b1; m_res = s ? li : 0;
        end else begin
          bnd   = (m_res == li);
          m_res = s ? ((m_res + 1 > li) ? li : m_res + 1) : (m_res + 1) % (li + 1);
        end
      end else begin
        if (m_res > li) begin
          m_res = m_res - 1;
        end else begin
          bnd   = (m_res == 0);
          m_res = s ? ((m_res == 0) ? 0 : m_res - 1) : (m_res + li) % (li + 1);
        end
      end
      m_tc = bnd;
      m_ov = bnd || (m_ov && !co);
    end else begin
      m_tc = 1'b0;
      if (co) m_ov = 1'b0;
    end
  endtask

  // Drive one edge's inputs on the 8-bit instance, advance model, sample after edge.
  task automatic step8(input logic c, input logic l, input logic [7:0] lv,
                       input logic e, input logic ud, input logic s,
                       input logic [7:0] lim, input logic co);
    bus8.clear = c; bus8.load = l; bus8.load_value = lv; bus8.enable = e;
    bus8.up_down = ud; bus8.saturate = s; bus8.limit = lim; bus8.clear_overflow = co;
    model_edge(c, l, lv, e, ud, s, lim, co);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic c, input logic l, input logic [7:0] lv,
                             input logic e, input logic ud, input logic s,
                             input logic [7:0] lim, input logic co,
                             input logic [7:0] r, input logic tc, input logic ov);
    vec_t x;
    x.c = c; x.l = l; x.lv = lv; x.e = e; x.ud = ud; x.s = s;
    x.lim = lim; x.co = co; x.r = r; x.tc = tc; x.ov = ov;
    return x;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [127:0] ones;
    int pulses;
    int pulse_edge;

    n_vec = 0; n_bad = 0;
    m_res = 0; m_tc = 1'b0; m_ov = 1'b0;
    ones  = '1;

    // Directed table: modulo-10 up/down, saturate, priority, sticky, load above limit
    tbl.push_back(v(1,0,8'd0,0,1,0,8'd9,0, 8'd0,0,0));
    for (int i = 1; i <= 12; i++)
      tbl.push_back(v(0,0,8'd0,1,1,0,8'd9,0, 8'(i % 10), (i == 10), (i >= 10)));
    tbl.push_back(v(0,0,8'd0,1,0,0,8'd9,0, 8'd1,0,1));
    tbl.push_back(v(0,0,8'd0,1,0,0,8'd9,0, 8'd0,0,1));
    tbl.push_back(v(0,0,8'd0,1,0,0,8'd9,0, 8'd9,1,1));
    tbl.push_back(v(0,0,8'd0,1,0,0,8'd9,0, 8'd8,0,1));
    tbl.push_back(v(0,1,8'd198,0,1,1,8'd200,0, 8'd198,0,1));
    tbl.push_back(v(0,0,8'd0,1,1,1,8'd200,0, 8'd199,0,1));
    tbl.push_back(v(0,0,8'd0,1,1,1,8'd200,0, 8'd200,0,1));
    tbl.push_back(v(0,0,8'd0,1,1,1,8'd200,0, 8'd200,1,1));
    tbl.push_back(v(0,0,8'd0,1,1,1,8'd200,0, 8'd200,1,1));
    tbl.push_back(v(0,0,8'd0,1,1,1,8'd200,0, 8'd200,1,1));
    tbl.push_back(v(0,1,8'd1,0,0,1,8'd200,0, 8'd1,0,1));
    tbl.push_back(v(0,0,8'd0,1,0,1,8'd200,0, 8'd0,0,1));
    tbl.push_back(v(0,0,8'd0,1,0,1,8'd200,0, 8'd0,1,1));
    tbl.push_back(v(1,1,8'h55,1,1,0,8'h10,0, 8'h00,0,0));
    tbl.push_back(v(0,1,8'h55,1,1,0,8'h10,0, 8'h55,0,0));
    tbl.push_back(v(0,0,8'd0,1,1,0,8'h10,0, 8'h00,1,1));
    tbl.push_back(v(0,0,8'd0,0,1,0,8'h10,1, 8'h00,0,0));
    tbl.push_back(v(0,0,8'd0,1,1,0,8'h00,1, 8'h00,1,1));
    tbl.push_back(v(0,0,8'd0,0,1,0,8'h00,0, 8'h00,0,1));
    tbl.push_back(v(0,0,8'd0,1,0,0,8'h00,0, 8'h00,1,1));
    tbl.push_back(v(0,1,8'd5,0,0,0,8'd3,0, 8'd5,0,1));
    tbl.push_back(v(0,0,8'd0,1,0,0,8'd3,0, 8'd4,0,1));
    tbl.push_back(v(0,0,8'd0,1,1,1,8'd3,0, 8'd3,1,1));
    tbl.push_back(v(0,0,8'd0,1,0,0,8'd3,1, 8'd2,0,0));

    // Idle inputs, reset asserted from time zero
    resetb = 1'b0;
    bus8.clear = 1'b0; bus8.load = 1'b0; bus8.load_value = '0; bus8.enable = 1'b0;
    bus8.up_down = 1'b1; bus8.saturate = 1'b0; bus8.limit = 8'hff; bus8.clear_overflow = 1'b0;
    bus128.clear = 1'b0; bus128.load = 1'b0; bus128.load_value = '0; bus128.enable = 1'b0;
    bus128.up_down = 1'b1; bus128.saturate = 1'b0; bus128.limit = '1; bus128.clear_overflow = 1'b0;
    #2;
    chk("reset_async_result", 128'(bus8.result), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", 128'(bus8.result), 128'd0);
    chk("reset_tc", 128'(bus8.terminal_count), 128'd0);
    chk("reset_ovf", 128'(bus8.overflow_sticky), 128'd0);
    resetb = 1'b1;

    // Full-range count: 300 edges, one pulse on edge 256
    pulses = 0; pulse_edge = 0;
    for (int i = 1; i <= 300; i++) begin
      step8(0, 0, 8'd0, 1, 1, 0, 8'd255, 0);
      if (bus8.terminal_count) begin
        pulses++;
        pulse_edge = i;
      end
    end
    chk("count300_result", 128'(bus8.result), 128'd44);
    chk("count300_pulses", 128'(pulses), 128'd1);
    chk("count300_pulse_edge", 128'(pulse_edge), 128'd256);
    chk("count300_ovf", 128'(bus8.overflow_sticky), 128'd1);

    // Reset mid-cycle returns to reset values without a clock edge
    #2 resetb = 1'b0;
    #1;
    chk("midreset_result", 128'(bus8.result), 128'd0);
    chk("midreset_tc", 128'(bus8.terminal_count), 128'd0);
    chk("midreset_ovf", 128'(bus8.overflow_sticky), 128'd0);
    m_res = 0; m_tc = 1'b0; m_ov = 1'b0;
    resetb = 1'b1;

    foreach (tbl[i]) begin
      step8(tbl[i].c, tbl[i].l, tbl[i].lv, tbl[i].e, tbl[i].ud, tbl[i].s, tbl[i].lim, tbl[i].co);
      chk($sformatf("tbl%0d_result", i), 128'(bus8.result), 128'(tbl[i].r));
      chk($sformatf("tbl%0d_tc", i), 128'(bus8.terminal_count), 128'(tbl[i].tc));
      chk($sformatf("tbl%0d_ovf", i), 128'(bus8.overflow_sticky), 128'(tbl[i].ov));
    end

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic       c, l, e, ud, s, co;
      logic [7:0] lv, lim;
      c   = ($urandom_range(0, 24) == 0);
      l   = ($urandom_range(0, 9) == 0);
      lv  = 8'($urandom);
      e   = ($urandom_range(0, 3) != 0);
      ud  = 1'($urandom);
      s   = 1'($urandom);
      lim = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      co  = ($urandom_range(0, 7) == 0);
      step8(c, l, lv, e, ud, s, lim, co);
      chk($sformatf("rand%0d_result", i), 128'(bus8.result), 128'(m_res));
      chk($sformatf("rand%0d_tc", i), 128'(bus8.terminal_count), 128'(m_tc));
      chk($sformatf("rand%0d_ovf", i), 128'(bus8.overflow_sticky), 128'(m_ov));
    end
    bus8.clear = 1'b0; bus8.load = 1'b0; bus8.enable = 1'b0; bus8.clear_overflow = 1'b0;

    // 128-bit full-range wrap through all-ones
    bus128.load = 1'b1; bus128.load_value = ones - 128'd1;
    @(posedge clk); #1;
    chk("w128_load", bus128.result, ones - 128'd1);
    bus128.load = 1'b0; bus128.enable = 1'b1; bus128.up_down = 1'b1;
    bus128.saturate = 1'b0; bus128.limit = ones;
    pulses = 0;
    @(posedge clk); #1;
    chk("w128_e1_result", bus128.result, ones);
    if (bus128.terminal_count) pulses++;
    @(posedge clk); #1;
    chk("w128_e2_result", bus128.result, 128'd0);
    chk("w128_e2_tc", 128'(bus128.terminal_count), 128'd1);
    if (bus128.terminal_count) pulses++;
    @(posedge clk); #1;
    chk("w128_e3_result", bus128.result, 128'd1);
    if (bus128.terminal_count) pulses++;
    chk("w128_pulses", 128'(pulses), 128'd1);
    chk("w128_ovf", 128'(bus128.overflow_sticky), 128'd1);

    // Asynchronous reset between edges
    #2 resetb = 1'b0;
    #1;
    chk("r128_result", bus128.result, 128'd0);
    chk("r128_tc", 128'(bus128.terminal_count), 128'd0);
    chk("r128_ovf", 128'(bus128.overflow_sticky), 128'd0);
    bus128.enable = 1'b0;
    resetb = 1'b1;
    @(posedge clk); #1;
    chk("r128_after_result", bus128.result, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_counter_modulo_updown_async_resetb

// File: doc/counter_modulo_updown_async_resetb.md
Name: counter_modulo_updown_async_resetb

Overview:
- Parametrised successor to the fixed-width asynchronous-reset counter in the simple_registers/counters micro-benchmarks.
- Adds configurable width, up/down direction, programmable modulo limit, wrap or saturate mode, synchronous load/clear, count enable, terminal-count pulse and sticky overflow flag.
- Used as a standalone register-heavy benchmark and as a timer/event-counter leaf.

Parameters:
- WIDTH, 128, counter width in bits (>= 2).
- RESET_VALUE, 0, value of result after resetb assertion (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- resetb  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear to RESET_VALUE.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value loaded when load=1.
- enable  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- saturate  input  1  1 = saturate at bound, 0 = wrap.
- limit  input  WIDTH  inclusive upper bound of count range [0, limit].
- clear_overflow  input  1  clears overflow_sticky.
- result  output  WIDTH  registered count value.
- terminal_count  output  1  registered one-cycle pulse on a bound event.
- overflow_sticky  output  1  set on any bound event; held until cleared.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - resetb=0 asynchronously forces result=RESET_VALUE, terminal_count=0, overflow_sticky=0, regardless of clk.
  - Outputs hold reset values while resetb=0. The first update occurs on the first rising clk edge after resetb deasserts.
- Per-edge priority (highest first): clear, load, enable. With none of these asserted, result holds.
  - clear=1: result<=RESET_VALUE; terminal_count<=0.
  - load=1: result<=load_value exactly, with no range check; terminal_count<=0.
  - enable=1, up_down=1:
    - result < limit: result<=result+1.
    - result >= limit (bound event), wrap mode: result<=0.
    - result >= limit (bound event), saturate mode: result<=limit.
  - enable=1, up_down=0:
    - result > 0: result<=result-1.
    - result == 0 (bound event), wrap mode: result<=limit.
    - result == 0 (bound event), saturate mode: result<=0.
  - enable=0: result holds; terminal_count<=0.
- Bound events:
  - terminal_count<=1 for exactly the edge on which a bound event is taken, otherwise 0.
  - While saturated with enable held, every edge is a bound event, so terminal_count stays high.
- Arithmetic:
  - All arithmetic is WIDTH bits and unsigned; no carry-out port.
  - limit = 2^WIDTH-1 gives natural full-range binary counting.
  - limit = 0 keeps result at 0 and makes every enabled edge a bound event.
- overflow_sticky:
  - Set on any bound event.
  - Cleared by clear_overflow or clear.
  - If set and clear_overflow coincide on the same edge, set wins (1).
- Latency: result and flags change one edge after the inputs are sampled. No combinational paths from inputs to outputs.
- limit may change at any time; it is sampled on every edge with no pipelining.
- Loading a value above limit is legal:
  - Up-count from there is an immediate bound event (wrap to 0 or saturate to limit).
  - Down-count decrements normally.
- Reset asserted mid-count: immediate asynchronous return to reset values. No pending event survives.

Decomposition:
- Shared package counters_pkg:
  - DIR_UP/DIR_DOWN and MODE_WRAP/MODE_SATURATE 1-bit constants.
  - Default WIDTH constant, shared by the counter benchmark family.
- One natural sub-module, counter_next_value: purely combinational.
  - Inputs: result, limit, up_down, saturate.
  - Outputs: next value and bound_event flag.
- Top module holds only the priority mux and registers.

Test Plan:
- Reset and basic count (WIDTH=8, limit=255, wrap, up, enable):
  - resetb low mid-cycle → result=0 immediately.
  - Release, run 300 edges → result=44 (300 mod 256).
  - terminal_count pulses exactly once, on the 256th edge; overflow_sticky=1 after it.
- Modulo and down-count wrap (WIDTH=8, limit=9):
  - Up for 12 edges → sequence 1..9,0,1,2; terminal_count on edge 10.
  - Switch up_down=0 from result=2 → 1,0,9,8; terminal_count on the 0→9 edge.
- Saturate mode (WIDTH=8, limit=200):
  - load 198, count up 5 edges → 199,200,200,200,200; terminal_count high for the last 3 edges.
  - Down-count from load 1 → 0,0; terminal_count high on the second edge.
- Priority and load above limit:
  - clear, load (load_value=0x55) and enable together → result=RESET_VALUE.
  - load+enable → 0x55.
  - With limit=0x10, wrap, up: next enabled edge → 0 with terminal_count=1.
- Sticky flag:
  - Bound event sets overflow_sticky.
  - clear_overflow on a non-event edge → 0.
  - clear_overflow coincident with a bound event → stays 1.
- Default WIDTH=128, limit=all-ones:
  - load 2^128-2, up 3 edges → 2^128-1, 0, 1; one terminal_count pulse.
  - Async reset between edges returns all outputs to 0.
